gpr_cdb_arbiter: RTL and testbench

Shares the single GPR common data bus between the integer functional units (add_sub, mov/shift, load, etc.). Each unit raises a req_if valid when it holds a dispatch-ready entry. The arbiter grants exactly one unit per cycle and captures that unit's ROB tag. One cycle later it broadcasts tag plus result on gpr_cdb, matching the units' registered-result timing. It sits between the unit req_if/tag/result outputs and every consumer of gpr_cdb: reservation stations, register file and ROB.

---
 rtl/gpr_cdb_arbiter_pkg.sv | 20 ++
 rtl/gpr_cdb_arbiter_rr_prio_pick.sv | 37 +++
 rtl/gpr_cdb_arbiter.sv | 90 +++++++++
 tb/tb_gpr_cdb_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/gpr_cdb_arbiter_pkg.sv
// Shared CDB definitions: ROB tag width, GPR CDB unit count, broadcast bus type
// and the tag-match helper used by CDB consumers.
package gpr_cdb_arbiter_pkg;

  localparam int unsigned ROB_WIDTH     = 4;
  localparam int unsigned GPR_CDB_N_REQ = 4;
  localparam int unsigned CDB_DATA_W    = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;

  // True when a live broadcast carries the given ROB tag.
  function automatic logic tag_match(cdb_t cdb, logic [ROB_WIDTH-1:0] tag);
    return cdb.valid && (cdb.tag == tag);
  endfunction

endpackage

// File: rtl/gpr_cdb_arbiter_rr_prio_pick.sv
// Round-robin priority pick: rotate requests so ptr sits at bit 0, take the
// lowest set bit, rotate the index back. Purely combinational; reusable per CDB.
module rr_prio_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [PW-1:0] idx_c,
  output logic          any_c
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;

  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[N-1:0];
    off     = '0;
    any_c   = |req;
    // Scan downward so the lowest set bit of the rotated vector wins.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot[k]) off = PW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    idx_c   = sum[PW-1:0];
    grant_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      grant_c[i] = any_c && (idx_c == PW'(i));
    end
  end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// GPR common data bus arbiter: round-robin grant in cycle N, broadcast of the
// captured tag plus the unit's registered result in cycle N+1.
// Optional GPR_CDB_STAT_EN adds the busy_cycles broadcast counter.
module gpr_cdb_arbiter
  import gpr_cdb_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = GPR_CDB_N_REQ,
  localparam int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*ROB_WIDTH-1:0]  req_tag,
  input  logic [N_REQ*CDB_DATA_W-1:0] req_result,
`ifdef GPR_CDB_STAT_EN
  output cdb_t                        gpr_cdb,
  output logic [31:0]                 busy_cycles
`else
  output cdb_t                        gpr_cdb
`endif
);

  logic [PW-1:0]        ptr;
  logic [PW-1:0]        sel;
  logic [ROB_WIDTH-1:0] tag_q;
  logic                 pend;

  logic [N_REQ-1:0]     pick_grant;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 grant_c;
  logic [PW-1:0]        ptr_nxt;
  logic [ROB_WIDTH-1:0] cap_tag;

  rr_prio_pick #(.N(N_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .grant_c (pick_grant),
    .idx_c   (pick_idx),
    .any_c   (pick_any)
  );

  // Grant is suppressed while reset is held so no unit dispatches into a cancelled slot.
  always_comb begin
    req_ready = reset ? '0 : pick_grant;
    grant_c   = pick_any && !reset;
    ptr_nxt   = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
    cap_tag   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_idx == PW'(i)) cap_tag = req_tag[ROB_WIDTH*i +: ROB_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      sel   <= '0;
      tag_q <= '0;
      pend  <= 1'b0;
    end else if (grant_c) begin
      ptr   <= ptr_nxt;
      sel   <= pick_idx;
      tag_q <= cap_tag;
      pend  <= 1'b1;
    end else begin
      pend  <= 1'b0;
    end
  end

  // Result mux uses the registered sel: units register their result at the grant edge.
  always_comb begin
    gpr_cdb.valid = pend;
    gpr_cdb.tag   = pend ? tag_q : 'x;
    gpr_cdb.data  = 'x;
    if (pend) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (sel == PW'(i)) gpr_cdb.data = req_result[CDB_DATA_W*i +: CDB_DATA_W];
      end
    end
  end

`ifdef GPR_CDB_STAT_EN
  always_ff @(posedge clk) begin
    if (reset)     busy_cycles <= '0;
    else if (pend) busy_cycles <= busy_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// Directed table-driven bench for gpr_cdb_arbiter (N_REQ=4, ROB_WIDTH=4).
module tb_gpr_cdb_arbiter;
  import gpr_cdb_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [15:0]  req_tag;
  logic [127:0] req_result;
  cdb_t         gpr_cdb;
`ifdef GPR_CDB_STAT_EN
  logic [31:0]  busy_cycles;
`endif

  always #5 clk = ~clk;

  gpr_cdb_arbiter #(.N_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_tag    (req_tag),
    .req_result (req_result),
`ifdef GPR_CDB_STAT_EN
    .gpr_cdb    (gpr_cdb),
    .busy_cycles(busy_cycles)
`else
    .gpr_cdb    (gpr_cdb)
`endif
  );

  typedef struct {
    bit           rst;
    logic [3:0]   valid;
    logic [15:0]  tags;
    logic [127:0] res;
    logic [3:0]   rdy;
    bit           ev;
    logic [3:0]   et;
    logic [31:0]  ed;
  } vec_t;

  localparam logic [15:0]  DEF_TAGS = {4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [127:0] DEF_RES  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

  vec_t tbl[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(bit rst, logic [3:0] valid, logic [3:0] rdy,
                              bit ev, logic [3:0] et, logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.valid = valid; v.tags = DEF_TAGS; v.res = DEF_RES;
    v.rdy = rdy; v.ev = ev; v.et = et; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    req_valid = '0;
    req_tag = DEF_TAGS;
    req_result = DEF_RES;

    // Reset with all units requesting, then first grant to unit 0.
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'd1, 32'hD0));
    // Lone requester unit 2 (tag 5), ptr=1, three grants; results follow a cycle later.
    v = mk(0, 4'b0100, 4'b0100, 0, 0, 0);        v.tags[11:8] = 4'd5; tbl.push_back(v);
    v = mk(0, 4'b0100, 4'b0100, 1, 4'd5, 32'h11); v.tags[11:8] = 4'd5; v.res[95:64] = 32'h11; tbl.push_back(v);
    v = mk(0, 4'b0100, 4'b0100, 1, 4'd5, 32'h22); v.tags[11:8] = 4'd5; v.res[95:64] = 32'h22; tbl.push_back(v);
    v = mk(0, 4'b0000, 4'b0000, 1, 4'd5, 32'h33); v.res[95:64] = 32'h33; tbl.push_back(v);
    // ptr=3 with units 0 and 2 requesting: 0, 2, 0.
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0100, 1, 4'd1, 32'hD0));
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 1, 4'd3, 32'hD2));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'd1, 32'hD0));
    // Move ptr to 0 via a lone grant to unit 3, then all four for 8 cycles.
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 4'd4, 32'hD3));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 1, 4'd1, 32'hD0));
    tbl.push_back(mk(0, 4'b1111, 4'b0100, 1, 4'd2, 32'hD1));
    tbl.push_back(mk(0, 4'b1111, 4'b1000, 1, 4'd3, 32'hD2));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 4'd4, 32'hD3));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 1, 4'd1, 32'hD0));
    tbl.push_back(mk(0, 4'b1111, 4'b0100, 1, 4'd2, 32'hD1));
    tbl.push_back(mk(0, 4'b1111, 4'b1000, 1, 4'd3, 32'hD2));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'd4, 32'hD3));
    // ptr to 1, then unit 1 (tag 9) requests while reset is asserted.
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 0, 0));
    v = mk(1, 4'b0010, 4'b0000, 1, 4'd1, 32'hD0); v.tags[7:4] = 4'd9; tbl.push_back(v);
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0));
    // ptr back at 0: units 0 and 1 requesting picks unit 0.
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'd1, 32'hD0));

    @(negedge clk);
    @(negedge clk);
    foreach (tbl[r]) begin
      @(negedge clk);
      reset      = tbl[r].rst;
      req_valid  = tbl[r].valid;
      req_tag    = tbl[r].tags;
      req_result = tbl[r].res;
      #1;
      chk($sformatf("row%0d ready", r), 32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("row%0d cdb_valid", r), 32'(gpr_cdb.valid), 32'(tbl[r].ev));
      if (tbl[r].ev) begin
        chk($sformatf("row%0d cdb_tag", r), 32'(gpr_cdb.tag), 32'(tbl[r].et));
        chk($sformatf("row%0d cdb_data", r), gpr_cdb.data, tbl[r].ed);
      end
    end

`ifdef GPR_CDB_STAT_EN
    // 10 broadcasts within 15 cycles after a fresh reset.
    @(negedge clk);
    reset = 1'b1; req_valid = '0; req_tag = DEF_TAGS; req_result = DEF_RES;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("busy_after_reset", busy_cycles, 32'd0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      req_valid = (c < 10) ? 4'b0001 : 4'b0000;
    end
    @(negedge clk);
    #1;
    chk("busy_count_10", busy_cycles, 32'd10);
`endif

    @(negedge clk);
    req_valid = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
